// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants and types for the VGA raster generator.
// Defaults describe 640x480@60 from a 100 MHz clock (25 MHz pixel rate).
package vga_timing_gen_pkg;

    localparam int CNT_W   = 10;
    localparam int CNT_MAX = 1 << CNT_W;

    localparam int DEF_DIV    = 4;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;

    typedef logic [CNT_W-1:0] count_t;

    // A raster dimension must be non-empty and addressable by a count_t.
    function automatic bit timingFits(input int total);
        return (total >= 1) && (total <= CNT_MAX);
    endfunction

endpackage

// File: rtl/pix_clk_div.sv
// Pixel-enable divider: free-running modulo-DIV counter with a one-clk
// pix_tick on its last state. The tick is suppressed while reset is held.
module pix_clk_div
    import vga_timing_gen_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic pix_tick
);

    localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

    logic [3:0] divCntReg;
    logic [3:0] divCntNext;

    always_comb begin
        divCntNext = divCntReg + 4'd1;
        if (divCntReg == DIV_LAST) begin
            divCntNext = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            divCntReg <= 4'd0;
        end else begin
            divCntReg <= divCntNext;
        end
    end

    // With DIV=1 the counter sits at 0 == DIV_LAST, so the tick is constant.
    assign pix_tick = (divCntReg == DIV_LAST) && !reset;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: h/v scan counters, registered sync/bright
// outputs aligned to the counts, and per-line / per-frame strobes.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int DIV    = DEF_DIV,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             hSync,
    output logic             vSync,
    output logic             bright,
    output logic             pix_tick,
    output logic             line_tick,
    output logic             frame_tick
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_VIS + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_VIS + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    generate
        if (!timingFits(H_TOTAL) || !timingFits(V_TOTAL) || DIV < 1 || DIV > 16) begin : g_badParams
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must be 1..1024 and DIV 1..16");
        end
    endgenerate

    localparam count_t H_LAST   = count_t'(H_TOTAL - 1);
    localparam count_t V_LAST   = count_t'(V_TOTAL - 1);
    localparam count_t H_SYNC_C = count_t'(H_SYNC);
    localparam count_t V_SYNC_C = count_t'(V_SYNC);
    // Window bounds are one bit wider: START+VIS may equal 1024.
    localparam logic [CNT_W:0] H_BEG = (CNT_W+1)'(H_START);
    localparam logic [CNT_W:0] H_END = (CNT_W+1)'(H_START + H_VIS);
    localparam logic [CNT_W:0] V_BEG = (CNT_W+1)'(V_START);
    localparam logic [CNT_W:0] V_END = (CNT_W+1)'(V_START + V_VIS);

    logic   pixTick;
    count_t hCountReg, hCountNext;
    count_t vCountReg, vCountNext;
    logic   hSyncReg, vSyncReg, brightReg;
    logic   hInWindow, vInWindow;

    pix_clk_div #(
        .DIV(DIV)
    ) u_pixDiv (
        .clk      (clk),
        .reset    (reset),
        .pix_tick (pixTick)
    );

    always_comb begin
        hCountNext = hCountReg;
        vCountNext = vCountReg;
        if (pixTick) begin
            if (hCountReg == H_LAST) begin
                hCountNext = '0;
                vCountNext = (vCountReg == V_LAST) ? '0 : vCountReg + 1'b1;
            end else begin
                hCountNext = hCountReg + 1'b1;
            end
        end
    end

    assign hInWindow = ({1'b0, hCountNext} >= H_BEG) && ({1'b0, hCountNext} < H_END);
    assign vInWindow = ({1'b0, vCountNext} >= V_BEG) && ({1'b0, vCountNext} < V_END);

    // Sync/bright decode the next-state counts so they register alongside them.
    always_ff @(posedge clk) begin
        if (reset) begin
            hCountReg <= '0;
            vCountReg <= '0;
            hSyncReg  <= 1'b0;
            vSyncReg  <= 1'b0;
            brightReg <= 1'b0;
        end else begin
            hCountReg <= hCountNext;
            vCountReg <= vCountNext;
            hSyncReg  <= !(hCountNext < H_SYNC_C);
            vSyncReg  <= !(vCountNext < V_SYNC_C);
            brightReg <= hInWindow && vInWindow;
        end
    end

    assign hCount     = hCountReg;
    assign vCount     = vCountReg;
    assign hSync      = hSyncReg;
    assign vSync      = vSyncReg;
    assign bright     = brightReg;
    assign pix_tick   = pixTick;
    assign line_tick  = pixTick && (hCountReg == H_LAST);
    assign frame_tick = line_tick && (vCountReg == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken raster (17x10 pixels),
// with one instance at DIV=4 and one at DIV=1, scored cycle by cycle.
module tb_vga_timing_gen;

    localparam int DIV  = 4;
    localparam int HS   = 4;
    localparam int HBP  = 3;
    localparam int HVIS = 8;
    localparam int HFP  = 2;
    localparam int VS   = 2;
    localparam int VBP  = 2;
    localparam int VVIS = 5;
    localparam int VFP  = 1;
    localparam int HT   = HS + HBP + HVIS + HFP;
    localparam int VT   = VS + VBP + VVIS + VFP;
    localparam int HST  = HS + HBP;
    localparam int VST  = VS + VBP;

    typedef logic [25:0] obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hCount, vCount, hCount1, vCount1;
    logic       hSync, vSync, bright, pix_tick, line_tick, frame_tick;
    logic       hSync1, vSync1, bright1, pix_tick1, line_tick1, frame_tick1;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .DIV(DIV), .H_SYNC(HS), .H_BP(HBP), .H_VIS(HVIS), .H_FP(HFP),
        .V_SYNC(VS), .V_BP(VBP), .V_VIS(VVIS), .V_FP(VFP)
    ) dut (
        .clk(clk), .reset(reset), .hCount(hCount), .vCount(vCount),
        .hSync(hSync), .vSync(vSync), .bright(bright), .pix_tick(pix_tick),
        .line_tick(line_tick), .frame_tick(frame_tick)
    );

    vga_timing_gen #(
        .DIV(1), .H_SYNC(HS), .H_BP(HBP), .H_VIS(HVIS), .H_FP(HFP),
        .V_SYNC(VS), .V_BP(VBP), .V_VIS(VVIS), .V_FP(VFP)
    ) dut1 (
        .clk(clk), .reset(reset), .hCount(hCount1), .vCount(vCount1),
        .hSync(hSync1), .vSync(vSync1), .bright(bright1), .pix_tick(pix_tick1),
        .line_tick(line_tick1), .frame_tick(frame_tick1)
    );

    obs_t expQ[$];
    obs_t exp1Q[$];
    int   errors = 0;
    int   checks = 0;
    int   c = 0;
    int   cyc = 0;
    int   nLine, nFrame, nBright, nHsLow, nVsLow;
    int   firstTickC, hAtDiv;
    int   lastFrame = -1, lastLine1 = -1, lastFrame1 = -1;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Closed-form raster: after c clocks out of reset, floor(c/div) pixels elapsed.
    function automatic obs_t model(input int cc, input bit rst, input int div);
        int p, h, v;
        bit pt, lt, ft, hs, vs, br;
        if (rst) return '0;
        p  = cc / div;
        h  = p % HT;
        v  = (p / HT) % VT;
        pt = (cc % div) == div - 1;
        lt = pt && (h == HT - 1);
        ft = lt && (v == VT - 1);
        hs = !(h < HS);
        vs = !(v < VS);
        br = (h >= HST) && (h < HST + HVIS) && (v >= VST) && (v < VST + VVIS);
        return {10'(h), 10'(v), hs, vs, br, pt, lt, ft};
    endfunction

    task automatic clearStats();
        nLine = 0; nFrame = 0; nBright = 0; nHsLow = 0; nVsLow = 0;
        firstTickC = -1; hAtDiv = -1;
    endtask

    task automatic step(input bit rst);
        reset = rst;
        @(posedge clk);
        cyc++;
        c = rst ? 0 : c + 1;
        expQ.push_back(model(c, rst, DIV));
        exp1Q.push_back(model(c, rst, 1));
        @(negedge clk);
        checkVal("raster", 32'({hCount, vCount, hSync, vSync, bright, pix_tick, line_tick, frame_tick}),
                 32'(expQ.pop_front()));
        checkVal("raster_div1", 32'({hCount1, vCount1, hSync1, vSync1, bright1, pix_tick1, line_tick1, frame_tick1}),
                 32'(exp1Q.pop_front()));
        if (rst) begin
            lastFrame = -1; lastLine1 = -1; lastFrame1 = -1;
        end else begin
            if (pix_tick && firstTickC < 0) firstTickC = c;
            if (c == DIV) hAtDiv = int'(hCount);
            if (pix_tick && bright) nBright++;
            if (pix_tick && !hSync) nHsLow++;
            if (pix_tick && !vSync) nVsLow++;
            if (line_tick) nLine++;
            if (frame_tick) begin
                nFrame++;
                if (lastFrame >= 0) checkVal("frame_period", 32'(cyc - lastFrame), 32'(HT * VT * DIV));
                lastFrame = cyc;
            end
            if (line_tick1) begin
                if (lastLine1 >= 0) checkVal("div1_line_period", 32'(cyc - lastLine1), 32'(HT));
                lastLine1 = cyc;
            end
            if (frame_tick1) begin
                if (lastFrame1 >= 0) checkVal("div1_frame_period", 32'(cyc - lastFrame1), 32'(HT * VT));
                lastFrame1 = cyc;
            end
        end
    endtask

    initial begin
        bit found;

        clearStats();
        repeat (3) step(1'b1);
        $display("[reset] held 3 clks, h=%0d v=%0d", hCount, vCount);

        // Two full frames straight out of reset.
        for (int i = 0; i < 2 * HT * VT * DIV; i++) step(1'b0);
        // c counts edges after the reset edge, so clk cycle DIV is c == DIV-1.
        checkVal("first_tick_c", 32'(firstTickC), 32'(DIV - 1));
        checkVal("h_after_first_tick", 32'(hAtDiv), 32'd1);
        checkVal("line_ticks", 32'(nLine), 32'(2 * VT));
        checkVal("frame_ticks", 32'(nFrame), 32'd2);
        checkVal("bright_pixels", 32'(nBright), 32'(2 * HVIS * VVIS));
        checkVal("hsync_low_pixels", 32'(nHsLow), 32'(2 * VT * HS));
        checkVal("vsync_low_pixels", 32'(nVsLow), 32'(2 * VS * HT));
        $display("[two_frames] lines=%0d frames=%0d bright=%0d", nLine, nFrame, nBright);

        // Seek a mid-frame position, then pulse reset for one clk.
        found = 1'b0;
        for (int i = 0; i < 4 * HT * VT * DIV && !found; i++) begin
            step(1'b0);
            if (hCount == 10'd10 && vCount == 10'd5) found = 1'b1;
        end
        checkVal("seek_mid_frame", 32'(found), 32'd1);
        step(1'b1);
        checkVal("reset_h", 32'(hCount), 32'd0);
        checkVal("reset_v", 32'(vCount), 32'd0);
        checkVal("reset_line_tick", 32'(line_tick), 32'd0);
        checkVal("reset_frame_tick", 32'(frame_tick1), 32'd0);
        clearStats();
        for (int i = 0; i < HT * VT * DIV; i++) step(1'b0);
        checkVal("post_reset_lines", 32'(nLine), 32'(VT));
        checkVal("post_reset_frames", 32'(nFrame), 32'd1);
        $display("[mid_reset] lines=%0d frames=%0d after 1-clk reset", nLine, nFrame);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
